// File: rtl/intra_pred_nxn.sv
// Streaming NxN luma intra predictor (4x4/8x8/16x16; Vertical, Horizontal, DC).
// Captures neighbours on start, optionally accumulates DC, then emits one row per handshake.
module intra_pred_nxn #(
  parameter int PIX_W     = 8,
  parameter int MAXN      = 16,
  parameter int LOG2_MAXN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              blk_size,
  input  logic [1:0]              mode,
  input  logic                    top_avail,
  input  logic                    left_avail,
  input  logic [MAXN*PIX_W-1:0]   top_pix,
  input  logic [MAXN*PIX_W-1:0]   left_pix,
  output logic                    busy,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [MAXN*PIX_W-1:0]   pred_row,
  output logic [LOG2_MAXN-1:0]    row_idx,
  output logic                    done,
  output logic                    mode_err
);

  localparam int ACC_W = PIX_W + LOG2_MAXN;
  // Wide enough to hold 4 << 3 so a reserved size compares as larger than MAXN.
  localparam int NW    = (LOG2_MAXN + 2 > 6) ? LOG2_MAXN + 2 : 6;

  localparam logic [1:0] MODE_V   = 2'd0;
  localparam logic [1:0] MODE_H   = 2'd1;
  localparam logic [1:0] MODE_DC  = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE, SUM, OUT, FIN} state_t;

  state_t                  state, next_state;
  logic [1:0]              blk_q, mode_q;
  logic                    top_av_q, left_av_q;
  logic [MAXN*PIX_W-1:0]   top_q, left_q;
  logic [ACC_W-1:0]        sum_t, sum_l;
  logic [LOG2_MAXN-1:0]    cnt;
  logic                    err_q, fin_hold;

  logic [NW-1:0]           req_n, n_q;
  logic                    req_err, sum_last, last_row, accept;
  logic [2:0]              log2n;
  logic [ACC_W:0]          dc_sum;
  logic [PIX_W-1:0]        dc_val;
  logic [LOG2_MAXN-1:0]    nxt_idx;
  logic [MAXN*PIX_W-1:0]   row_next;

  assign req_n   = NW'(4) << blk_size;
  assign req_err = (req_n > NW'(MAXN)) || (mode == MODE_RSV) ||
                   (mode == MODE_V && !top_avail) || (mode == MODE_H && !left_avail);

  assign n_q      = NW'(4) << blk_q;
  assign log2n    = {1'b0, blk_q} + 3'd2;
  assign sum_last = (NW'(cnt) == n_q - NW'(1));
  assign last_row = (NW'(row_idx) == n_q - NW'(1));
  assign accept   = row_valid && row_ready;
  assign nxt_idx  = row_valid ? row_idx + LOG2_MAXN'(1) : '0;

  // An invalid request spends one held cycle in FIN so done lands two cycles after start.
  assign busy     = (state != IDLE);
  assign done     = (state == FIN) && !fin_hold;
  assign mode_err = done && err_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dc_sum = '0;
    case ({top_av_q, left_av_q})
      2'b11:   dc_sum = ({1'b0, sum_t} + {1'b0, sum_l} + (ACC_W+1)'(n_q)) >> (log2n + 3'd1);
      2'b10:   dc_sum = ({1'b0, sum_t} + (ACC_W+1)'(n_q >> 1)) >> log2n;
      2'b01:   dc_sum = ({1'b0, sum_l} + (ACC_W+1)'(n_q >> 1)) >> log2n;
      default: dc_sum = (ACC_W+1)'(1) << (PIX_W - 1);
    endcase
    dc_val = dc_sum[PIX_W-1:0];
  end

  always_comb begin
    row_next = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < int'(n_q)) begin
        case (mode_q)
          MODE_V:  row_next[i*PIX_W +: PIX_W] = top_q[i*PIX_W +: PIX_W];
          MODE_H:  row_next[i*PIX_W +: PIX_W] = left_q[int'(nxt_idx)*PIX_W +: PIX_W];
          default: row_next[i*PIX_W +: PIX_W] = dc_val;
        endcase
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_err)               next_state = FIN;
          else if (mode == MODE_DC)  next_state = SUM;
          else                       next_state = OUT;
        end
      end
      SUM:     if (sum_last)            next_state = OUT;
      OUT:     if (accept && last_row)  next_state = FIN;
      FIN:     if (!fin_hold)           next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q     <= '0;
      mode_q    <= '0;
      top_av_q  <= 1'b0;
      left_av_q <= 1'b0;
      top_q     <= '0;
      left_q    <= '0;
      sum_t     <= '0;
      sum_l     <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      fin_hold  <= 1'b0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      pred_row  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            blk_q     <= blk_size;
            mode_q    <= mode;
            top_av_q  <= top_avail;
            left_av_q <= left_avail;
            top_q     <= top_pix;
            left_q    <= left_pix;
            sum_t     <= '0;
            sum_l     <= '0;
            cnt       <= '0;
            err_q     <= req_err;
            fin_hold  <= req_err;
          end
        end
        SUM: begin
          sum_t <= sum_t + ACC_W'(top_q[int'(cnt)*PIX_W +: PIX_W]);
          sum_l <= sum_l + ACC_W'(left_q[int'(cnt)*PIX_W +: PIX_W]);
          cnt   <= cnt + LOG2_MAXN'(1);
        end
        OUT: begin
          if (!row_valid || row_ready) begin
            if (row_valid && last_row) begin
              row_valid <= 1'b0;
            end else begin
              row_valid <= 1'b1;
              row_idx   <= nxt_idx;
              pred_row  <= row_next;
            end
          end
        end
        FIN: begin
          fin_hold <= 1'b0;
          row_idx  <= '0;
          pred_row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_pred_nxn.sv
// Directed bench for intra_pred_nxn: a vector table of blocks with hand-computed
// results, plus hand-written reset-abort and mid-block start sequences.
module tb_intra_pred_nxn;
  localparam int PIX_W = 8, MAXN = 16, LOG2_MAXN = 4, W = MAXN * PIX_W;

  logic                 clk = 1'b0;
  logic                 reset, start, top_avail, left_avail, row_ready;
  logic [1:0]           blk_size, mode;
  logic [W-1:0]         top_pix, left_pix, pred_row;
  logic                 busy, row_valid, done, mode_err;
  logic [LOG2_MAXN-1:0] row_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  intra_pred_nxn #(.PIX_W(PIX_W), .MAXN(MAXN), .LOG2_MAXN(LOG2_MAXN)) dut (
    .clk(clk), .reset(reset), .start(start), .blk_size(blk_size), .mode(mode),
    .top_avail(top_avail), .left_avail(left_avail), .top_pix(top_pix), .left_pix(left_pix),
    .busy(busy), .row_valid(row_valid), .row_ready(row_ready), .pred_row(pred_row),
    .row_idx(row_idx), .done(done), .mode_err(mode_err)
  );

  typedef struct {
    logic [1:0]       blk, mode;
    logic             tav, lav;
    logic [W-1:0]     top, left;
    bit               tog;
    bit               err;
    logic [PIX_W-1:0] dc;
    int               first;
    int               done_cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string what, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fill(input logic [PIX_W-1:0] v);
    logic [W-1:0] f;
    for (int i = 0; i < MAXN; i++) f[i*PIX_W +: PIX_W] = v;
    return f;
  endfunction

  function automatic logic [W-1:0] exp_row(input vec_t v, input int r);
    logic [W-1:0] e;
    int n;
    e = '0;
    n = 4 << v.blk;
    for (int i = 0; i < n && i < MAXN; i++) begin
      case (v.mode)
        2'd0:    e[i*PIX_W +: PIX_W] = v.top[i*PIX_W +: PIX_W];
        2'd1:    e[i*PIX_W +: PIX_W] = v.left[r*PIX_W +: PIX_W];
        default: e[i*PIX_W +: PIX_W] = v.dc;
      endcase
    end
    return e;
  endfunction

  // Start one block, scramble the inputs afterwards, pulse a stray start mid-block,
  // and compare every presented row plus first-row and done timing.
  task automatic run_vec(input int id, input vec_t v);
    int n, rows, first, done_cyc;
    n = v.err ? 0 : (4 << v.blk);
    rows = 0;
    first = -1;
    done_cyc = -1;
    check($sformatf("v%0d idle_before", id), W'(busy), W'(1'b0));
    blk_size = v.blk; mode = v.mode; top_avail = v.tav; left_avail = v.lav;
    top_pix = v.top; left_pix = v.left; row_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
      step;
      start = (c == 3) && !v.err;
      if (c == 1) begin
        check($sformatf("v%0d busy_c1", id), W'(busy), W'(1'b1));
        top_pix    = {$urandom(), $urandom(), $urandom(), $urandom()};
        left_pix   = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode       = 2'($urandom_range(0, 3));
        blk_size   = 2'($urandom_range(0, 3));
        top_avail  = 1'($urandom_range(0, 1));
        left_avail = 1'($urandom_range(0, 1));
      end
      row_ready = v.tog ? ((c % 2) == 0) : 1'b1;
      if (row_valid) begin
        if (first < 0) first = c;
        check($sformatf("v%0d row_in_range", id), W'(rows < n), W'(1'b1));
        if (rows < n) begin
          check($sformatf("v%0d row_idx", id), W'(row_idx), W'(rows));
          check($sformatf("v%0d pred_row r%0d", id, rows), pred_row, exp_row(v, rows));
        end
        if (row_ready) rows++;
      end
      if (mode_err && !done) check($sformatf("v%0d mode_err_alone", id), W'(mode_err), W'(1'b0));
      if (done) begin
        done_cyc = c;
        check($sformatf("v%0d mode_err", id), W'(mode_err), W'(v.err));
      end
    end
    start = 1'b0;
    check($sformatf("v%0d done_cycle", id), W'(done_cyc), W'(v.done_cyc));
    check($sformatf("v%0d rows", id), W'(rows), W'(n));
    check($sformatf("v%0d first_row", id), W'(first), W'(v.first));
    step;
    row_ready = 1'b1;
    check($sformatf("v%0d done_pulse", id), W'(done), W'(1'b0));
    check($sformatf("v%0d busy_after", id), W'(busy), W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t;
    bit found, saw_done;

    // 16x16 DC, top=10 left=20: (160+320+16)>>5 = 15.
    t = '{blk:2, mode:2, tav:1, lav:1, top:fill(10), left:fill(20), tog:0, err:0,
          dc:15, first:18, done_cyc:34};
    vecs[0] = t;
    // 4x4 V, top 1,2,3,4 then 99.
    t = '{blk:0, mode:0, tav:1, lav:0, top:fill(99), left:fill(0), tog:0, err:0,
          dc:0, first:2, done_cyc:6};
    for (int i = 0; i < 4; i++) t.top[i*PIX_W +: PIX_W] = PIX_W'(i + 1);
    vecs[1] = t;
    // 8x8 H, left[j]=j*8, ready toggling: row r accepted at 2+2r, done at 17.
    t = '{blk:1, mode:1, tav:0, lav:1, top:fill(0), left:fill(0), tog:1, err:0,
          dc:0, first:2, done_cyc:17};
    for (int j = 0; j < MAXN; j++) t.left[j*PIX_W +: PIX_W] = PIX_W'(j * 8);
    vecs[2] = t;
    // 4x4 DC top only, top=3,3,3,4: (13+2)>>2 = 3.
    t = '{blk:0, mode:2, tav:1, lav:0, top:fill(50), left:fill(77), tog:0, err:0,
          dc:3, first:6, done_cyc:10};
    t.top[31:0] = 32'h04030303;
    vecs[3] = t;
    // 4x4 DC left only, left=255: (1020+2)>>2 = 255.
    vecs[4] = '{blk:0, mode:2, tav:0, lav:1, top:fill(1), left:fill(255), tog:0, err:0,
                dc:255, first:6, done_cyc:10};
    // 4x4 DC neither: 128.
    vecs[5] = '{blk:0, mode:2, tav:0, lav:0, top:fill(9), left:fill(9), tog:0, err:0,
                dc:128, first:6, done_cyc:10};
    // Errors: V without top, size 3, mode 3.
    vecs[6] = '{blk:1, mode:0, tav:0, lav:1, top:fill(5), left:fill(5), tog:0, err:1,
                dc:0, first:-1, done_cyc:2};
    vecs[7] = '{blk:3, mode:2, tav:1, lav:1, top:fill(5), left:fill(5), tog:0, err:1,
                dc:0, first:-1, done_cyc:2};
    vecs[8] = '{blk:0, mode:3, tav:1, lav:1, top:fill(5), left:fill(5), tog:0, err:1,
                dc:0, first:-1, done_cyc:2};
    // 8x8 DC both, top=0..7 (lanes 8+ = 200, unused), left=100: (28+800+8)>>4 = 52.
    t = '{blk:1, mode:2, tav:1, lav:1, top:fill(200), left:fill(100), tog:0, err:0,
          dc:52, first:10, done_cyc:18};
    for (int i = 0; i < 8; i++) t.top[i*PIX_W +: PIX_W] = PIX_W'(i);
    vecs[9] = t;
    // 16x16 V, top[i]=i*16+1.
    t = '{blk:2, mode:0, tav:1, lav:0, top:fill(0), left:fill(0), tog:0, err:0,
          dc:0, first:2, done_cyc:18};
    for (int i = 0; i < MAXN; i++) t.top[i*PIX_W +: PIX_W] = PIX_W'(i * 16 + 1);
    vecs[10] = t;

    reset = 1'b1; start = 1'b0; blk_size = '0; mode = '0; top_avail = 1'b0;
    left_avail = 1'b0; top_pix = '0; left_pix = '0; row_ready = 1'b0;
    repeat (3) step;
    check("rst busy", W'(busy), W'(1'b0));
    check("rst row_valid", W'(row_valid), W'(1'b0));
    check("rst done", W'(done), W'(1'b0));
    check("rst mode_err", W'(mode_err), W'(1'b0));
    check("rst pred_row", pred_row, W'(0));
    check("rst row_idx", W'(row_idx), W'(0));
    reset = 1'b0;
    step;

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

    // Reset while row 5 of a 16x16 block is on the output aborts with no done.
    blk_size = vecs[10].blk; mode = vecs[10].mode; top_avail = vecs[10].tav;
    left_avail = vecs[10].lav; top_pix = vecs[10].top; left_pix = vecs[10].left;
    row_ready = 1'b1; start = 1'b1;
    step;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (row_valid && row_idx == LOG2_MAXN'(5)) found = 1'b1;
      else step;
    end
    check("abort reached_row5", W'(found), W'(1'b1));
    reset = 1'b1;
    step;
    check("abort busy", W'(busy), W'(1'b0));
    check("abort row_valid", W'(row_valid), W'(1'b0));
    check("abort done", W'(done), W'(1'b0));
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step;
      if (done || busy || row_valid) saw_done = 1'b1;
    end
    check("abort quiet_after", W'(saw_done), W'(1'b0));
    run_vec(11, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intra_pred_nxn.md
Name: intra_pred_nxn

Overview:
- Parametrised successor to the fixed 16x16 luma intra predictor: one engine covers 4x4, 8x8 and 16x16 blocks and Vertical, Horizontal and DC modes.
- Follows H.264 neighbour-availability rules for DC.
- Unlike the single-cycle predictor, it streams the prediction one row per cycle under a valid/ready handshake to the residual/reconstruction stage.
- Sits between the neighbour-pixel buffer and the mode decision/residual path.

Parameters:
- PIX_W, 8, pixel bit width.
- MAXN, 16, largest block edge supported; power of two, minimum 4.
- LOG2_MAXN, 4, log2(MAXN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new block; accepted only when busy=0.
- blk_size  in  2  0=4x4, 1=8x8, 2=16x16, 3=reserved (treated as invalid).
- mode  in  2  0=Vertical, 1=Horizontal, 2=DC, 3=reserved (invalid).
- top_avail  in  1  top neighbours valid.
- left_avail  in  1  left neighbours valid.
- top_pix  in  MAXN*PIX_W  top neighbours; pixel i at bits [i*PIX_W +: PIX_W].
- left_pix  in  MAXN*PIX_W  left neighbours; pixel j at bits [j*PIX_W +: PIX_W].
- busy  out  1  block in progress.
- row_valid  out  1  pred_row/row_idx valid.
- row_ready  in  1  downstream accepts the row.
- pred_row  out  MAXN*PIX_W  one prediction row; lanes >= N are zero.
- row_idx  out  LOG2_MAXN  index of the current row.
- done  out  1  one-cycle pulse after the last row is accepted, or on error.
- mode_err  out  1  one-cycle pulse, coincident with done, on an invalid request.

Behaviour:
- Reset (sync, active-high) clears all outputs to 0 and puts the FSM in IDLE. Reset mid-block aborts the block with no done pulse. Reset has priority over every other input.
- States: IDLE, SUM, OUT, FIN.
- IDLE:
  - start=1 captures blk_size, mode, avail flags, top_pix and left_pix into internal registers. busy=1 from the next cycle.
  - N = 4 << blk_size.
  - Invalid request goes to FIN with mode_err=1 and no rows. Invalid means any of: blk_size=3 (or N > MAXN); mode=3; mode=V with top_avail=0; mode=H with left_avail=0.
  - Valid DC goes to SUM. Valid V or H goes straight to OUT.
- SUM (DC only): runs exactly N cycles. Each cycle adds top[k] into sum_t and left[k] into sum_l, k = 0..N-1. Accumulators are PIX_W+LOG2_MAXN bits wide, cleared on entry. After N cycles, compute dc and go to OUT:
  - both available: (sum_t + sum_l + N) >> (log2N + 1).
  - top only: (sum_t + N/2) >> log2N.
  - left only: (sum_l + N/2) >> log2N.
  - neither: 1 << (PIX_W-1).
  - The result is always in range; no clipping.
- OUT:
  - row r = 0..N-1 is presented with row_valid=1 and row_idx=r.
  - V: lane i = top[i]. H: every lane = left[r]. DC: every lane = dc. Lanes i >= N are 0.
  - Row r advances only on row_valid & row_ready. pred_row and row_idx hold stable while row_ready=0.
  - The first row is valid on the cycle after entering OUT; with row_ready held high, one row per cycle.
  - After row N-1 is accepted, go to FIN.
- FIN: done=1 for one cycle, row_valid=0, busy=0 next cycle, return to IDLE.
- start while busy=1 is ignored with no queuing. start in the same cycle as FIN is ignored; it is accepted the following cycle.
- Latency from start, with row_ready=1:
  - V/H: first row at cycle 2, done at cycle N+2.
  - DC: first row at cycle N+2, done at cycle 2N+2.
- Input changes after the start cycle have no effect on the block in progress.

Test Plan:
- 16x16 DC, all top=10, all left=20, both avail, row_ready=1 -> 16 rows, every lane 15; first row_valid 18 cycles after start; done at cycle 34.
- 4x4 V, top=1,2,3,4,(rest 99), top_avail=1 -> 4 rows each lanes 1,2,3,4 then lanes 4..15 zero; row_idx 0..3; done one pulse.
- 8x8 H, left[j]=j*8; row_ready toggled 1,0,1,0 -> row j lanes 0..7 = j*8; rows held stable on ready=0; exactly 8 handshakes.
- DC, 4x4: top only, top=3,3,3,4 -> dc=(13+2)>>2=3. Left only, left=255x4 -> 255. Neither -> 128.
- Errors -> done and mode_err pulse together two cycles after start, no row_valid, busy back to 0:
  - mode=V with top_avail=0.
  - blk_size=3.
  - mode=3.
- Reset asserted during OUT row 5 of 16x16 -> next cycle busy=0, row_valid=0, no done; a new start then runs normally.
